// File: rtl/read_iq.sv
// -----------------------------------------------------------------------------
// read_iq
//
// Purpose:
//   Pulls a little-endian byte stream from an upstream first-word-fall-through
//   FIFO. Four consecutive bytes (I_lo, I_hi, Q_lo, Q_hi) form one I/Q pair of
//   16-bit two's-complement raw samples. Each raw sample is sign-extended to
//   DATA_WIDTH and shifted left by BITS, with the bits shifted out discarded
//   and no saturation. The pair is then written to two downstream FIFOs with a
//   single joint write strobe.
//
// Optional feature:
//   READ_IQ_SAMPLE_COUNT_EN - when defined, sample_count counts written I/Q
//   pairs and wraps from 0xFFFFFFFF to 0. When undefined, sample_count is tied
//   to 0 and no counter is built.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_empty     in   upstream byte FIFO empty flag
//   in_rd_en     out  pop request to the upstream FIFO (combinational)
//   in_dout      in   head byte of the upstream FIFO [BYTE_WIDTH]
//   I_out_full   in   downstream I FIFO full flag
//   Q_out_full   in   downstream Q FIFO full flag
//   I_out_wr_en  out  I FIFO write strobe (always paired with Q_out_wr_en)
//   Q_out_wr_en  out  Q FIFO write strobe (always paired with I_out_wr_en)
//   I_din        out  quantized I sample, registered [DATA_WIDTH]
//   Q_din        out  quantized Q sample, registered [DATA_WIDTH]
//   sample_count out  number of I/Q pairs written [32]
//
// Assumes DATA_WIDTH > 16 and BYTE_WIDTH == 8 (two bytes per raw sample).
// -----------------------------------------------------------------------------
module read_iq #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int BITS       = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    input  logic [BYTE_WIDTH-1:0] in_dout,
    input  logic                  I_out_full,
    input  logic                  Q_out_full,
    output logic                  I_out_wr_en,
    output logic                  Q_out_wr_en,
    output logic [DATA_WIDTH-1:0] I_din,
    output logic [DATA_WIDTH-1:0] Q_din,
    output logic [31:0]           sample_count
);

    typedef enum logic [2:0] {
        S_I_LO  = 3'd0,
        S_I_HI  = 3'd1,
        S_Q_LO  = 3'd2,
        S_Q_HI  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    // Sign-extend a 16-bit raw sample to DATA_WIDTH and shift left by BITS.
    // Bits pushed past the MSB are simply lost (wrap, no saturation).
    function automatic logic [DATA_WIDTH-1:0] quantize(input logic [15:0] raw);
        logic [DATA_WIDTH-1:0] ext;
        ext = {{(DATA_WIDTH-16){raw[15]}}, raw};
        return ext << BITS;
    endfunction

    state_t                state_q;
    state_t                state_d;
    logic [BYTE_WIDTH-1:0] i_lo_q;
    logic [BYTE_WIDTH-1:0] i_lo_d;
    logic [BYTE_WIDTH-1:0] i_hi_q;
    logic [BYTE_WIDTH-1:0] i_hi_d;
    logic [BYTE_WIDTH-1:0] q_lo_q;
    logic [BYTE_WIDTH-1:0] q_lo_d;
    logic [DATA_WIDTH-1:0] i_din_q;
    logic [DATA_WIDTH-1:0] i_din_d;
    logic [DATA_WIDTH-1:0] q_din_q;
    logic [DATA_WIDTH-1:0] q_din_d;

    logic                  byte_state_s;
    logic                  pop_s;
    logic                  write_s;

    // Pop / write qualifiers. Reset masks both so no handshake fires while the
    // block is being cleared; S_WRITE is excluded from popping so pops and
    // writes never share a cycle.
    always_comb begin
        byte_state_s = 1'b0;
        case (state_q)
            S_I_LO, S_I_HI, S_Q_LO, S_Q_HI: byte_state_s = 1'b1;
            S_WRITE:                        byte_state_s = 1'b0;
            default:                        byte_state_s = 1'b0;
        endcase
        pop_s   = byte_state_s && !in_empty && !reset;
        write_s = (state_q == S_WRITE) && !I_out_full && !Q_out_full && !reset;
    end

    // FSM: state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_I_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic. Byte states advance only on a pop; S_WRITE waits
    // for both downstream FIFOs to have room.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_I_LO: begin
                if (pop_s) state_d = S_I_HI;
                else       state_d = S_I_LO;
            end
            S_I_HI: begin
                if (pop_s) state_d = S_Q_LO;
                else       state_d = S_I_HI;
            end
            S_Q_LO: begin
                if (pop_s) state_d = S_Q_HI;
                else       state_d = S_Q_LO;
            end
            S_Q_HI: begin
                if (pop_s) state_d = S_WRITE;
                else       state_d = S_Q_HI;
            end
            S_WRITE: begin
                if (write_s) state_d = S_I_LO;
                else         state_d = S_WRITE;
            end
            default: state_d = S_I_LO;
        endcase
    end

    // FSM: outputs. Strobes are combinational so the write lands in the very
    // cycle after the Q_hi pop edge.
    always_comb begin
        in_rd_en    = pop_s;
        I_out_wr_en = write_s;
        Q_out_wr_en = write_s;
    end

    // Byte capture and sample assembly. The Q_hi byte is taken straight from
    // in_dout on its pop edge, so both quantized outputs are registered in the
    // same edge that enters S_WRITE and stay put until the next pair completes.
    always_comb begin
        i_lo_d  = i_lo_q;
        i_hi_d  = i_hi_q;
        q_lo_d  = q_lo_q;
        i_din_d = i_din_q;
        q_din_d = q_din_q;
        case (state_q)
            S_I_LO: begin
                if (pop_s) i_lo_d = in_dout;
                else       i_lo_d = i_lo_q;
            end
            S_I_HI: begin
                if (pop_s) i_hi_d = in_dout;
                else       i_hi_d = i_hi_q;
            end
            S_Q_LO: begin
                if (pop_s) q_lo_d = in_dout;
                else       q_lo_d = q_lo_q;
            end
            S_Q_HI: begin
                if (pop_s) begin
                    i_din_d = quantize({i_hi_q[7:0], i_lo_q[7:0]});
                    q_din_d = quantize({in_dout[7:0], q_lo_q[7:0]});
                end else begin
                    i_din_d = i_din_q;
                    q_din_d = q_din_q;
                end
            end
            S_WRITE: begin
                i_din_d = i_din_q;
                q_din_d = q_din_q;
            end
            default: begin
                i_din_d = i_din_q;
                q_din_d = q_din_q;
            end
        endcase
    end

    // Data registers; reset discards any partially assembled pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            i_lo_q  <= {BYTE_WIDTH{1'b0}};
            i_hi_q  <= {BYTE_WIDTH{1'b0}};
            q_lo_q  <= {BYTE_WIDTH{1'b0}};
            i_din_q <= {DATA_WIDTH{1'b0}};
            q_din_q <= {DATA_WIDTH{1'b0}};
        end else begin
            i_lo_q  <= i_lo_d;
            i_hi_q  <= i_hi_d;
            q_lo_q  <= q_lo_d;
            i_din_q <= i_din_d;
            q_din_q <= q_din_d;
        end
    end

    assign I_din = i_din_q;
    assign Q_din = q_din_q;

`ifdef READ_IQ_SAMPLE_COUNT_EN
    logic [31:0] count_q;
    logic [31:0] count_d;

    // Written-pair counter; natural 32-bit wrap.
    always_comb begin
        if (write_s) count_d = count_q + 32'd1;
        else         count_d = count_q;
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sample_count = count_q;
`else
    assign sample_count = 32'd0;
`endif

endmodule

// File: tb/tb_read_iq.sv
module tb_read_iq;

    logic        clock;
    logic        reset;
    logic        in_empty;
    logic        in_rd_en;
    logic [7:0]  in_dout;
    logic        I_out_full;
    logic        Q_out_full;
    logic        I_out_wr_en;
    logic        Q_out_wr_en;
    logic [31:0] I_din;
    logic [31:0] Q_din;
    logic [31:0] sample_count;

    int n_total;
    int n_pass;
    int writes;
    logic toggle;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] ei;
        logic [31:0] eq;
    } vec_t;

    vec_t vecs [6];
    vec_t rst_vec;

    read_iq #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .BITS(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_empty     (in_empty),
        .in_rd_en     (in_rd_en),
        .in_dout      (in_dout),
        .I_out_full   (I_out_full),
        .Q_out_full   (Q_out_full),
        .I_out_wr_en  (I_out_wr_en),
        .Q_out_wr_en  (Q_out_wr_en),
        .I_din        (I_din),
        .Q_din        (Q_din),
        .sample_count (sample_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] exp_count(input int w);
`ifdef READ_IQ_SAMPLE_COUNT_EN
        return w;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Feed one sample (optionally with a gap every other cycle) and hold the
    // write off for full_cycles cycles with I or Q full.
    task automatic run_sample(input vec_t v, input bit gappy, input int full_cycles, input bit use_q);
        logic [7:0] bl [4];
        int k;
        int guard;
        bl[0] = v.b0; bl[1] = v.b1; bl[2] = v.b2; bl[3] = v.b3;
        k = 0;
        guard = 0;
        while (k < 4 && guard < 40) begin
            toggle   = gappy ? ~toggle : 1'b0;
            in_empty = toggle;
            in_dout  = toggle ? 8'hEE : bl[k];
            #1;
            check("rd_en", {31'd0, in_rd_en}, {31'd0, ~toggle});
            check("wr_idle", {30'd0, I_out_wr_en, Q_out_wr_en}, 32'd0);
            @(posedge clock); #1;
            if (!toggle) k++;
            guard++;
        end
        if (k < 4) check("pop_timeout", k, 32'd4);
        // Now in S_WRITE: offer a byte to confirm no pop happens here.
        in_empty = 1'b0;
        in_dout  = 8'hAA;
        for (int c = 0; c < full_cycles; c++) begin
            if (use_q) Q_out_full = 1'b1;
            else       I_out_full = 1'b1;
            #1;
            check("rd_in_write_full", {31'd0, in_rd_en}, 32'd0);
            check("wr_blocked", {30'd0, I_out_wr_en, Q_out_wr_en}, 32'd0);
            check("I_hold", I_din, v.ei);
            check("Q_hold", Q_din, v.eq);
            @(posedge clock); #1;
        end
        I_out_full = 1'b0;
        Q_out_full = 1'b0;
        #1;
        check("rd_in_write", {31'd0, in_rd_en}, 32'd0);
        check("wr_pair", {30'd0, I_out_wr_en, Q_out_wr_en}, 32'd3);
        check("I_din", I_din, v.ei);
        check("Q_din", Q_din, v.eq);
        writes++;
        in_empty = 1'b1;
        @(posedge clock); #1;
        check("wr_after", {30'd0, I_out_wr_en, Q_out_wr_en}, 32'd0);
        check("sample_count", sample_count, exp_count(writes));
    endtask

    initial begin
        n_total = 0; n_pass = 0; writes = 0; toggle = 1'b0;
        vecs[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 32'h0048D000, 32'h0159E000};
        vecs[1] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 32'hFFFFFC00, 32'hFE000000};
        vecs[2] = '{8'h01, 8'h00, 8'h02, 8'h00, 32'h00000400, 32'h00000800};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 32'h00000000};
        vecs[4] = '{8'hFF, 8'h7F, 8'h01, 8'h00, 32'h01FFFC00, 32'h00000400};
        vecs[5] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 32'hFE000000, 32'h01FFFC00};
        rst_vec = '{8'h01, 8'h00, 8'h02, 8'h00, 32'h00000400, 32'h00000800};

        reset = 1'b1; in_empty = 1'b1; in_dout = 8'h00;
        I_out_full = 1'b0; Q_out_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        in_empty = 1'b0; in_dout = 8'h34;
        #1;
        check("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
        check("rst_wr", {30'd0, I_out_wr_en, Q_out_wr_en}, 32'd0);
        check("rst_I_din", I_din, 32'd0);
        check("rst_Q_din", Q_din, 32'd0);
        check("rst_count", sample_count, 32'd0);
        in_empty = 1'b1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Straight-through vectors, no gaps, no back-pressure.
        for (int i = 0; i < 6; i++) run_sample(vecs[i], 1'b0, 0, 1'b0);

        // Back-pressure: I full 3 cycles, then Q full 2 cycles.
        run_sample(vecs[0], 1'b0, 3, 1'b0);
        run_sample(vecs[5], 1'b0, 2, 1'b1);

        // Input gaps every other cycle, 4 consecutive samples.
        for (int i = 1; i < 5; i++) run_sample(vecs[i], 1'b1, 0, 1'b0);

        // Reset after two popped bytes discards the partial pair.
        toggle = 1'b0;
        in_empty = 1'b0; in_dout = 8'h55;
        #1;
        check("pre_rst_pop", {31'd0, in_rd_en}, 32'd1);
        @(posedge clock); #1;
        in_dout = 8'h66;
        @(posedge clock); #1;
        reset = 1'b1; in_dout = 8'h77;
        #1;
        check("mid_rst_rd_en", {31'd0, in_rd_en}, 32'd0);
        @(posedge clock); #1;
        check("mid_rst_I_din", I_din, 32'd0);
        check("mid_rst_count", sample_count, 32'd0);
        reset = 1'b0; in_empty = 1'b1;
        writes = 0;
        run_sample(rst_vec, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
